// File: rtl/seg_scan_driver_if.sv
// Host-side bundle for the 4-digit seven-segment scan driver.
// duty exists only when SEG_DIM_EN is defined.
interface seg_scan_driver_if;
  logic        en;
  logic        load;
  logic [27:0] seg_code;
`ifdef SEG_DIM_EN
  logic [3:0]  duty;
`endif
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        upd_pend;

`ifdef SEG_DIM_EN
  modport master (
    output en, load, seg_code, duty,
    input  seg, an, frame_start, upd_pend
  );
  modport slave (
    input  en, load, seg_code, duty,
    output seg, an, frame_start, upd_pend
  );
`else
  modport master (
    output en, load, seg_code,
    input  seg, an, frame_start, upd_pend
  );
  modport slave (
    input  en, load, seg_code,
    output seg, an, frame_start, upd_pend
  );
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 4-digit scan driver, frame-synchronous update.
// Optional per-dwell dimming is enabled by defining SEG_DIM_EN.
module seg_scan_driver #(
  parameter int         DIV_LOG2 = 16,
  parameter logic [6:0] SEG_OFF  = 7'b1111111
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);

  if (DIV_LOG2 < 4 || DIV_LOG2 > 24) begin : gBadDiv
    $error("seg_scan_driver: DIV_LOG2 out of range 4..24");
  end

  logic [DIV_LOG2-1:0] cnt;
  logic [1:0]          idx;
  logic [27:0]         pending;
  logic [27:0]         display;
  logic                pendV;
  logic                wrapD;
  logic [6:0]          segQ;
  logic [3:0]          anQ;
  logic                frameQ;

  logic       tc;
  logic       boundary;
  logic       gateOpen;
  logic       lit;
  logic [6:0] segSel;
  logic [3:0] anSel;

  assign tc       = &cnt;
  assign boundary = tc && (idx == 2'd3);

`ifdef SEG_DIM_EN
  // On-time sits at the start of each dwell: top nibble of cnt vs duty.
  assign gateOpen = (cnt[DIV_LOG2-1 -: 4] <= bus.duty);
`else
  assign gateOpen = 1'b1;
`endif

  assign lit   = bus.en && gateOpen;
  assign anSel = ~(4'b0001 << idx);

  always_comb begin
    segSel = SEG_OFF;
    unique case (idx)
      2'd0: segSel = display[27:21];
      2'd1: segSel = display[20:14];
      2'd2: segSel = display[13:7];
      2'd3: segSel = display[6:0];
      default: segSel = SEG_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= 2'd0;
      pending <= '0;
      pendV   <= 1'b0;
      display <= {4{SEG_OFF}};
      wrapD   <= 1'b0;
      anQ     <= 4'b1111;
      segQ    <= SEG_OFF;
      frameQ  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (tc) begin
        idx <= idx + 2'd1;
      end

      // A load on the boundary cycle bypasses the pending buffer.
      if (boundary) begin
        if (bus.load) begin
          display <= bus.seg_code;
        end else if (pendV) begin
          display <= pending;
        end
        pendV <= 1'b0;
      end else if (bus.load) begin
        pending <= bus.seg_code;
        pendV   <= 1'b1;
      end

      anQ  <= lit ? anSel : 4'b1111;
      segQ <= lit ? segSel : SEG_OFF;

      // Two stages so the pulse lines up with digit0's first output.
      wrapD  <= boundary;
      frameQ <= wrapD;
    end
  end

  assign bus.seg         = segQ;
  assign bus.an          = anQ;
  assign bus.frame_start = frameQ;
  assign bus.upd_pend    = pendV;

endmodule
